// File: rtl/byte_bus_bridge_if.sv
// Pin-side byte lanes and memory request/response signals of the byte bus bridge.
// master: the bridge itself; slave: the surrounding pins/fabric (or a bench).
interface byte_bus_bridge_if;
    logic        frm_start;
    logic        rw_in;
    logic [7:0]  addr_byte;
    logic [7:0]  wdata_byte;
    logic [7:0]  rdata_byte;
    logic        rdata_oe;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        err;

    modport master (
        input  frm_start, rw_in, addr_byte, wdata_byte,
        input  mem_req_ready, mem_rsp_valid, mem_rdata,
        output rdata_byte, rdata_oe,
        output mem_req_valid, mem_addr, mem_wdata, mem_we,
        output busy, err
    );

    modport slave (
        output frm_start, rw_in, addr_byte, wdata_byte,
        output mem_req_ready, mem_rsp_valid, mem_rdata,
        input  rdata_byte, rdata_oe,
        input  mem_req_valid, mem_addr, mem_wdata, mem_we,
        input  busy, err
    );
endinterface

// File: rtl/byte_bus_bridge.sv
// Captures a 4-beat little-endian byte frame into a 32-bit memory request and streams
// read data back bytewise. Define BRIDGE_TIMEOUT_EN to bound the read-response wait.
module byte_bus_bridge #(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input logic               clk,
    input logic               rst_n,
    byte_bus_bridge_if.master bus
);
    typedef enum logic [2:0] {IDLE, CAP, REQ, WAIT, DRV} state_e;

    state_e      state_q, state_d;
    logic [1:0]  beat_q, beat_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rd_q, rd_d;
    logic [4:0]  lane_sel;

    // One beat counter serves both byte capture (CAP) and byte replay (DRV).
    assign lane_sel = {beat_q, 3'b000};

`ifdef BRIDGE_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          tmo_hit;

    // Last permitted wait cycle; a response arriving here still wins.
    assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYC - 1));
`endif

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rd_d    = rd_q;
`ifdef BRIDGE_TIMEOUT_EN
        tmo_d   = tmo_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.frm_start) begin
                    addr_d  = {24'h0, bus.addr_byte};
                    wdata_d = {24'h0, bus.wdata_byte};
                    rd_d    = bus.rw_in;
                    beat_d  = 2'd1;
                    state_d = CAP;
`ifdef BRIDGE_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            CAP: begin
                addr_d[lane_sel +: 8]  = bus.addr_byte;
                wdata_d[lane_sel +: 8] = bus.wdata_byte;
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.mem_req_ready) begin
                    state_d = rd_q ? WAIT : IDLE;
`ifdef BRIDGE_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            WAIT: begin
                if (bus.mem_rsp_valid) begin
                    rdata_d = bus.mem_rdata;
                    state_d = DRV;
                end
`ifdef BRIDGE_TIMEOUT_EN
                else if (tmo_hit) begin
                    rdata_d = ERR_DATA;
                    err_d   = 1'b1;
                    state_d = DRV;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            DRV: begin
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rd_q    <= rd_d;
        end
    end

`ifdef BRIDGE_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{ERR_DATA, TIMEOUT_CYC};
    assign bus.err    = 1'b0;
`endif

    assign bus.busy          = (state_q != IDLE);
    assign bus.mem_req_valid = (state_q == REQ);
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.mem_we        = (state_q == REQ) && !rd_q;
    assign bus.rdata_oe      = (state_q == DRV);
    assign bus.rdata_byte    = (state_q == DRV) ? rdata_q[lane_sel +: 8] : 8'h00;
endmodule

// File: tb/tb_byte_bus_bridge.sv
// Bench for byte_bus_bridge: directed frame table, reset/noise sequences, and random
// frames checked against a little-endian transaction model. Honours BRIDGE_TIMEOUT_EN.
module tb_byte_bus_bridge;
    localparam int unsigned TMO  = 64;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst_n;

    byte_bus_bridge_if bus();

    byte_bus_bridge #(
        .TIMEOUT_CYC(TMO),
        .ERR_DATA   (ERRD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    typedef logic [3:0][7:0] bytes4_t;

    typedef struct {
        bit          rw;
        bytes4_t     ab;
        bytes4_t     wb;
        int          rdy_dly;
        int          rsp_dly;   // wait cycles before rsp; negative = never respond
        logic [31:0] rsp;
        logic [31:0] x_addr;
        logic [31:0] x_wdata;
        bit          x_we;
        bytes4_t     x_rb;
        bit          x_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] le_word(input bytes4_t b);
        logic [31:0] w = 32'h0;
        for (int i = 0; i < 4; i++) w = w + (32'(b[i]) << (8 * i));
        return w;
    endfunction

    function automatic bytes4_t le_bytes(input logic [31:0] w);
        bytes4_t b;
        for (int i = 0; i < 4; i++) b[i] = 8'((w >> (8 * i)) & 32'hFF);
        return b;
    endfunction

    function automatic vec_t mk(input bit rw, input bytes4_t ab, input bytes4_t wb,
                                input int rdy, input int rsd, input logic [31:0] rsp,
                                input logic [31:0] xa, input logic [31:0] xw,
                                input bytes4_t xrb, input bit xerr);
        vec_t v;
        v.rw = rw; v.ab = ab; v.wb = wb; v.rdy_dly = rdy; v.rsp_dly = rsd; v.rsp = rsp;
        v.x_addr = xa; v.x_wdata = xw; v.x_we = !rw; v.x_rb = xrb; v.x_err = xerr;
        return v;
    endfunction

    task automatic zero_checks(input string tag);
        chk({tag, "_busy"},  32'(bus.busy), 32'd0);
        chk({tag, "_valid"}, 32'(bus.mem_req_valid), 32'd0);
        chk({tag, "_we"},    32'(bus.mem_we), 32'd0);
        chk({tag, "_addr"},  bus.mem_addr, 32'd0);
        chk({tag, "_wdata"}, bus.mem_wdata, 32'd0);
        chk({tag, "_oe"},    32'(bus.rdata_oe), 32'd0);
        chk({tag, "_rbyte"}, 32'(bus.rdata_byte), 32'd0);
        chk({tag, "_err"},   32'(bus.err), 32'd0);
    endtask

    task automatic quiet_inputs();
        bus.frm_start = 1'b0; bus.rw_in = 1'b0; bus.addr_byte = '0; bus.wdata_byte = '0;
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        quiet_inputs();
        #1;
        zero_checks("midrst");
        step();
        rst_n = 1'b1;
    endtask

    task automatic noise_lanes(input bit noise);
        bus.frm_start  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.rw_in      = 1'($urandom_range(0, 1));
        bus.addr_byte  = noise ? 8'($urandom) : 8'h00;
        bus.wdata_byte = noise ? 8'($urandom) : 8'h00;
    endtask

    // Caller is in an idle cycle; returns in an idle cycle (or right after a reset).
    task automatic run_frame(input vec_t v, input int rst_pt, input bit noise);
        int n;
        chk("t_busy", 32'(bus.busy), 32'd0);
        bus.frm_start = 1'b1; bus.rw_in = v.rw;
        bus.addr_byte = v.ab[0]; bus.wdata_byte = v.wb[0];
        step();
        for (int b = 1; b < 4; b++) begin
            bus.frm_start  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.rw_in      = noise ? ~v.rw : v.rw;
            bus.addr_byte  = v.ab[b];
            bus.wdata_byte = v.wb[b];
            chk("cap_busy", 32'(bus.busy), 32'd1);
            chk("cap_valid", 32'(bus.mem_req_valid), 32'd0);
            if (b == 1) chk("cap_err_clr", 32'(bus.err), 32'd0);
            if (rst_pt == 1 && b == 2) begin
                do_reset();
                return;
            end
            step();
        end
        for (int k = 0; k <= v.rdy_dly; k++) begin
            noise_lanes(noise);
            bus.mem_req_ready = (k == v.rdy_dly);
            bus.mem_rsp_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.mem_rdata     = $urandom;
            chk("req_valid", 32'(bus.mem_req_valid), 32'd1);
            chk("req_addr", bus.mem_addr, v.x_addr);
            chk("req_wdata", bus.mem_wdata, v.x_wdata);
            chk("req_we", 32'(bus.mem_we), 32'(v.x_we));
            chk("req_oe", 32'(bus.rdata_oe), 32'd0);
            step();
        end
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        if (!v.rw) begin
            noise_lanes(1'b0);
            chk("wr_done_busy", 32'(bus.busy), 32'd0);
            chk("wr_done_valid", 32'(bus.mem_req_valid), 32'd0);
        end else begin
            n = (v.rsp_dly < 0) ? int'(TMO) : v.rsp_dly;
            for (int k = 0; k < n; k++) begin
                noise_lanes(noise);
                chk("wait_busy", 32'(bus.busy), 32'd1);
                chk("wait_oe", 32'(bus.rdata_oe), 32'd0);
                chk("wait_valid", 32'(bus.mem_req_valid), 32'd0);
                step();
            end
            if (v.rsp_dly >= 0) begin
                noise_lanes(noise);
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rdata     = v.rsp;
                chk("rsp_oe", 32'(bus.rdata_oe), 32'd0);
                step();
                bus.mem_rsp_valid = 1'b0;
                bus.mem_rdata     = $urandom;
            end
            for (int b = 0; b < 4; b++) begin
                noise_lanes(noise);
                chk("drv_oe", 32'(bus.rdata_oe), 32'd1);
                chk("drv_byte", 32'(bus.rdata_byte), 32'(v.x_rb[b]));
                chk("drv_err", 32'(bus.err), 32'(v.x_err));
                if (rst_pt == 2 && b == 1) begin
                    do_reset();
                    return;
                end
                step();
            end
            noise_lanes(1'b0);
            chk("end_oe", 32'(bus.rdata_oe), 32'd0);
            chk("end_byte", 32'(bus.rdata_byte), 32'd0);
            chk("end_busy", 32'(bus.busy), 32'd0);
        end
        chk("end_err", 32'(bus.err), 32'(v.x_err));
    endtask

    // One idle cycle, optionally with a stray response that must be ignored.
    task automatic idle_gap(input bit stray);
        bus.frm_start     = 1'b0;
        bus.mem_rsp_valid = stray;
        bus.mem_rdata     = $urandom;
        chk("gap_busy", 32'(bus.busy), 32'd0);
        chk("gap_valid", 32'(bus.mem_req_valid), 32'd0);
        step();
        bus.mem_rsp_valid = 1'b0;
        chk("gap_busy2", 32'(bus.busy), 32'd0);
        chk("gap_oe", 32'(bus.rdata_oe), 32'd0);
        chk("gap_rbyte", 32'(bus.rdata_byte), 32'd0);
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;

        tbl.push_back(mk(1'b0, {8'h12, 8'h34, 8'h56, 8'h78}, {8'hDE, 8'hAD, 8'hBE, 8'hEF},
                         0, 0, 32'h0, 32'h1234_5678, 32'hDEAD_BEEF, '0, 1'b0));
        tbl.push_back(mk(1'b1, {8'h00, 8'h00, 8'h00, 8'h10}, {8'h11, 8'h22, 8'h33, 8'h44},
                         3, 0, 32'hCAFE_F00D, 32'h0000_0010, 32'h1122_3344,
                         {8'hCA, 8'hFE, 8'hF0, 8'h0D}, 1'b0));
        tbl.push_back(mk(1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, {8'h00, 8'h00, 8'h00, 8'h00},
                         0, 0, 32'h0102_0304, 32'hFFFF_FFFF, 32'h0000_0000,
                         {8'h01, 8'h02, 8'h03, 8'h04}, 1'b0));
        tbl.push_back(mk(1'b1, {8'h80, 8'h00, 8'h00, 8'h01}, {8'h5A, 8'hA5, 8'h5A, 8'hA5},
                         1, 5, 32'h8899_AABB, 32'h8000_0001, 32'h5AA5_5AA5,
                         {8'h88, 8'h99, 8'hAA, 8'hBB}, 1'b0));
        tbl.push_back(mk(1'b0, {8'hA5, 8'hA5, 8'h5A, 8'h5A}, {8'hFF, 8'hFF, 8'hFF, 8'hFF},
                         2, 0, 32'h0, 32'hA5A5_5A5A, 32'hFFFF_FFFF, '0, 1'b0));
`ifndef BRIDGE_TIMEOUT_EN
        tbl.push_back(mk(1'b1, {8'h00, 8'h00, 8'h01, 8'h00}, {8'h00, 8'h00, 8'h00, 8'h00},
                         0, 80, 32'h1357_9BDF, 32'h0000_0100, 32'h0000_0000,
                         {8'h13, 8'h57, 8'h9B, 8'hDF}, 1'b0));
`endif

        rst_n = 1'b0;
        quiet_inputs();
        step();
        step();
        zero_checks("por");
        rst_n = 1'b1;
        idle_gap(1'b0);

        foreach (tbl[i]) begin
            run_frame(tbl[i], 0, 1'b0);
            idle_gap(1'b1);
        end

        run_frame(tbl[1], 1, 1'b0);
        idle_gap(1'b0);
        run_frame(tbl[0], 0, 1'b0);
        idle_gap(1'b0);
        run_frame(tbl[3], 2, 1'b0);
        idle_gap(1'b0);
        run_frame(tbl[1], 0, 1'b0);
        idle_gap(1'b0);

        run_frame(tbl[1], 0, 1'b1);
        idle_gap(1'b1);
        run_frame(tbl[0], 0, 1'b1);
        idle_gap(1'b1);

`ifdef BRIDGE_TIMEOUT_EN
        run_frame(mk(1'b1, {8'h00, 8'h00, 8'h00, 8'h40}, {8'h00, 8'h00, 8'h00, 8'h00},
                     0, -1, 32'h0, 32'h0000_0040, 32'h0000_0000,
                     {8'hDE, 8'hAD, 8'hBE, 8'hEF}, 1'b1), 0, 1'b0);
        chk("tmo_err_held", 32'(bus.err), 32'd1);
        idle_gap(1'b0);
        chk("tmo_err_idle", 32'(bus.err), 32'd1);
        run_frame(tbl[2], 0, 1'b0);
        idle_gap(1'b0);
        run_frame(mk(1'b1, {8'h00, 8'h00, 8'h00, 8'h44}, {8'h00, 8'h00, 8'h00, 8'h00},
                     1, 63, 32'h2468_ACE0, 32'h0000_0044, 32'h0000_0000,
                     {8'h24, 8'h68, 8'hAC, 8'hE0}, 1'b0), 0, 1'b0);
        idle_gap(1'b0);
`endif

        for (int i = 0; i < 60; i++) begin
            v.rw      = 1'($urandom_range(0, 1));
            v.ab      = bytes4_t'($urandom);
            v.wb      = bytes4_t'($urandom);
            v.rdy_dly = int'($urandom_range(0, 3));
            v.rsp_dly = int'($urandom_range(0, 6));
            v.rsp     = $urandom;
            v.x_addr  = le_word(v.ab);
            v.x_wdata = le_word(v.wb);
            v.x_we    = !v.rw;
            v.x_rb    = le_bytes(v.rsp);
            v.x_err   = 1'b0;
            run_frame(v, 0, 1'($urandom_range(0, 1)));
            idle_gap(1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
